reg_universal: RTL and testbench

//  Parametrised multi-mode register: load, byte-lane load, increment/decrement by STEP, shift left/right, hold.

---
 rtl/ureg_pkg.sv | 13 +
 rtl/reg_universal_next.sv | 69 ++++++
 rtl/reg_universal.sv | 94 +++++++++
 tb/tb_reg_universal.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ureg_pkg.sv
// Shared MODE encodings for the universal register and the CPU control decoder.
package ureg_pkg;

    localparam logic [2:0] UREG_HOLD    = 3'b000;
    localparam logic [2:0] UREG_LOAD    = 3'b001;
    localparam logic [2:0] UREG_INC     = 3'b010;
    localparam logic [2:0] UREG_DEC     = 3'b011;
    localparam logic [2:0] UREG_SHL     = 3'b100;
    localparam logic [2:0] UREG_SHR     = 3'b101;
    localparam logic [2:0] UREG_LOAD_LO = 3'b110;
    localparam logic [2:0] UREG_LOAD_HI = 3'b111;

endpackage

// File: rtl/reg_universal_next.sv
// Combinational next-value / next-carry logic for reg_universal.
module reg_universal_next
    import ureg_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned STEP  = 1
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic [2:0]       mode_i,
    input  logic             ser_in_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] next_o,
    output logic             next_carry_o
);

    localparam int unsigned Half = WIDTH / 2;
    localparam logic [WIDTH:0] StepW = (WIDTH + 1)'(STEP);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // One extra bit catches carry-out on INC and borrow on DEC.
    assign sum  = {1'b0, cur_i} + StepW;
    assign diff = {1'b0, cur_i} - StepW;

    // Decode MODE; anything unrecognised (including X) holds.
    always_comb begin
        next_o       = cur_i;
        next_carry_o = carry_i;
        case (mode_i)
            UREG_HOLD: begin
                next_o       = cur_i;
                next_carry_o = carry_i;
            end
            UREG_LOAD: begin
                next_o       = in_i;
                next_carry_o = 1'b0;
            end
            UREG_INC: begin
                next_o       = sum[WIDTH-1:0];
                next_carry_o = sum[WIDTH];
            end
            UREG_DEC: begin
                next_o       = diff[WIDTH-1:0];
                next_carry_o = diff[WIDTH];
            end
            UREG_SHL: begin
                next_o       = {cur_i[WIDTH-2:0], ser_in_i};
                next_carry_o = cur_i[WIDTH-1];
            end
            UREG_SHR: begin
                next_o       = {ser_in_i, cur_i[WIDTH-1:1]};
                next_carry_o = cur_i[0];
            end
            UREG_LOAD_LO: begin
                next_o = {cur_i[WIDTH-1:Half], in_i[Half-1:0]};
            end
            UREG_LOAD_HI: begin
                next_o = {in_i[Half-1:0], cur_i[Half-1:0]};
            end
            default: begin
                next_o       = cur_i;
                next_carry_o = carry_i;
            end
        endcase
    end

endmodule

// File: rtl/reg_universal.sv
// Multi-mode register (load, byte-lane load, inc/dec by STEP, shifts, hold).
// Optional shadow context register for interrupt save/restore: define UREG_SHADOW_EN.
module reg_universal
    import ureg_pkg::*;
#(
    parameter int unsigned     WIDTH     = 16,
    parameter int unsigned     STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] IN,
    input  logic [2:0]       MODE,
    input  logic             SER_IN,
    input  logic             SAVE,
    input  logic             RESTORE,
    output logic [WIDTH-1:0] OUT,
    output logic             CARRY,
    output logic             ZERO
);

    logic [WIDTH-1:0] out_q, out_d, nxt_value;
    logic             carry_q, carry_d, nxt_carry;

    reg_universal_next #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_next (
        .cur_i        (out_q),
        .in_i         (IN),
        .mode_i       (MODE),
        .ser_in_i     (SER_IN),
        .carry_i      (carry_q),
        .next_o       (nxt_value),
        .next_carry_o (nxt_carry)
    );

`ifdef UREG_SHADOW_EN
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             shadow_c_q, shadow_c_d;

    // Restore overrides MODE; save captures pre-edge state, so both together swap.
    always_comb begin
        out_d      = nxt_value;
        carry_d    = nxt_carry;
        shadow_d   = shadow_q;
        shadow_c_d = shadow_c_q;
        if (RESTORE) begin
            out_d   = shadow_q;
            carry_d = shadow_c_q;
        end
        if (SAVE) begin
            shadow_d   = out_q;
            shadow_c_d = carry_q;
        end
    end

    // Shadow flops with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            shadow_q   <= RESET_VAL;
            shadow_c_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            shadow_c_q <= shadow_c_d;
        end
    end
`else
    logic unused_shadow_ctrl;
    assign unused_shadow_ctrl = SAVE ^ RESTORE;

    // Without shadow storage the next state is just the decoded MODE result.
    always_comb begin
        out_d   = nxt_value;
        carry_d = nxt_carry;
    end
`endif

    // Main state flops with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            out_q   <= RESET_VAL;
            carry_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

    assign OUT   = out_q;
    assign CARRY = carry_q;
    assign ZERO  = (out_q == '0);

endmodule

// File: tb/tb_reg_universal.sv
// Directed self-checking bench for reg_universal (default and STEP=4/RESET_VAL=2 instances).
module tb_reg_universal;
    import ureg_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [15:0] IN = '0;
    logic [2:0]  MODE = UREG_HOLD;
    logic        SER_IN = 1'b0;
    logic        SAVE = 1'b0;
    logic        RESTORE = 1'b0;
    logic [15:0] OUT;
    logic        CARRY;
    logic        ZERO;

    logic [2:0]  mode4 = UREG_HOLD;
    logic [15:0] out4;
    logic        carry4;
    logic        zero4;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    reg_universal #(
        .WIDTH     (16),
        .STEP      (1),
        .RESET_VAL (16'h0000)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .IN      (IN),
        .MODE    (MODE),
        .SER_IN  (SER_IN),
        .SAVE    (SAVE),
        .RESTORE (RESTORE),
        .OUT     (OUT),
        .CARRY   (CARRY),
        .ZERO    (ZERO)
    );

    reg_universal #(
        .WIDTH     (16),
        .STEP      (4),
        .RESET_VAL (16'h0002)
    ) dut4 (
        .CLK     (CLK),
        .RESET   (RESET),
        .IN      (16'h0000),
        .MODE    (mode4),
        .SER_IN  (1'b0),
        .SAVE    (1'b0),
        .RESTORE (1'b0),
        .OUT     (out4),
        .CARRY   (carry4),
        .ZERO    (zero4)
    );

    // Apply one cycle of stimulus, then settle just past the rising edge.
    task automatic cyc(input logic [2:0] m, input logic [15:0] d, input logic s);
        MODE   = m;
        IN     = d;
        SER_IN = s;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RESET = 1'b0;
        cyc(UREG_LOAD, 16'hBEEF, 1'b0);
        cyc(UREG_LOAD, 16'hBEEF, 1'b0);
        tests++;
        if (OUT !== 16'h0000) begin fails++; $display("FAIL reset_out got %h want 0000", OUT); end
        tests++;
        if (CARRY !== 1'b0) begin fails++; $display("FAIL reset_carry got %b want 0", CARRY); end
        tests++;
        if (ZERO !== 1'b1) begin fails++; $display("FAIL reset_zero got %b want 1", ZERO); end
        tests++;
        if (out4 !== 16'h0002 || zero4 !== 1'b0) begin
            fails++; $display("FAIL reset_val4 got %h/%b want 0002/0", out4, zero4);
        end
        RESET = 1'b1;
    endtask

    task automatic test_inc_dec_wrap;
        cyc(UREG_LOAD, 16'hFFFF, 1'b0);
        tests++;
        if (OUT !== 16'hFFFF || ZERO !== 1'b0) begin
            fails++; $display("FAIL load_ffff got %h/%b want ffff/0", OUT, ZERO);
        end
        cyc(UREG_INC, 16'h0000, 1'b0);
        tests++;
        if (OUT !== 16'h0000 || CARRY !== 1'b1 || ZERO !== 1'b1) begin
            fails++; $display("FAIL inc_wrap got %h/%b/%b want 0000/1/1", OUT, CARRY, ZERO);
        end
        cyc(UREG_DEC, 16'h0000, 1'b0);
        tests++;
        if (OUT !== 16'hFFFF || CARRY !== 1'b1 || ZERO !== 1'b0) begin
            fails++; $display("FAIL dec_wrap got %h/%b/%b want ffff/1/0", OUT, CARRY, ZERO);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(UREG_HOLD, 16'h1234, 1'b1);
            tests++;
            if (OUT !== 16'hFFFF || CARRY !== 1'b1) begin
                fails++; $display("FAIL hold_%0d got %h/%b want ffff/1", i, OUT, CARRY);
            end
        end
        cyc(UREG_LOAD, 16'h1234, 1'b0);
        cyc(UREG_INC, 16'h0000, 1'b0);
        tests++;
        if (OUT !== 16'h1235 || CARRY !== 1'b0) begin
            fails++; $display("FAIL inc_plain got %h/%b want 1235/0", OUT, CARRY);
        end
        cyc(UREG_DEC, 16'h0000, 1'b0);
        cyc(UREG_DEC, 16'h0000, 1'b0);
        tests++;
        if (OUT !== 16'h1233 || CARRY !== 1'b0) begin
            fails++; $display("FAIL dec_plain got %h/%b want 1233/0", OUT, CARRY);
        end
    endtask

    task automatic test_shift;
        cyc(UREG_LOAD, 16'h8001, 1'b0);
        cyc(UREG_SHL, 16'h0000, 1'b0);
        tests++;
        if (OUT !== 16'h0002 || CARRY !== 1'b1) begin
            fails++; $display("FAIL shl got %h/%b want 0002/1", OUT, CARRY);
        end
        cyc(UREG_SHR, 16'h0000, 1'b1);
        tests++;
        if (OUT !== 16'h8001 || CARRY !== 1'b0) begin
            fails++; $display("FAIL shr got %h/%b want 8001/0", OUT, CARRY);
        end
        cyc(UREG_SHR, 16'h0000, 1'b0);
        tests++;
        if (OUT !== 16'h4000 || CARRY !== 1'b1) begin
            fails++; $display("FAIL shr_out got %h/%b want 4000/1", OUT, CARRY);
        end
        cyc(UREG_SHL, 16'h0000, 1'b1);
        tests++;
        if (OUT !== 16'h8001 || CARRY !== 1'b0) begin
            fails++; $display("FAIL shl_in got %h/%b want 8001/0", OUT, CARRY);
        end
    endtask

    task automatic test_byte_lanes;
        cyc(UREG_LOAD, 16'h0000, 1'b0);
        cyc(UREG_LOAD_LO, 16'h0034, 1'b0);
        tests++;
        if (OUT !== 16'h0034 || CARRY !== 1'b0) begin
            fails++; $display("FAIL load_lo got %h/%b want 0034/0", OUT, CARRY);
        end
        // Upper IN bits must be ignored by LOAD_HI.
        cyc(UREG_LOAD_HI, 16'hAB12, 1'b0);
        tests++;
        if (OUT !== 16'h1234 || CARRY !== 1'b0) begin
            fails++; $display("FAIL load_hi got %h/%b want 1234/0", OUT, CARRY);
        end
        // Set CARRY, then confirm both lane loads preserve it.
        cyc(UREG_LOAD, 16'hFFFF, 1'b0);
        cyc(UREG_INC, 16'h0000, 1'b0);
        cyc(UREG_LOAD_LO, 16'hFF56, 1'b0);
        tests++;
        if (OUT !== 16'h0056 || CARRY !== 1'b1) begin
            fails++; $display("FAIL load_lo_c got %h/%b want 0056/1", OUT, CARRY);
        end
        cyc(UREG_LOAD_HI, 16'h0078, 1'b0);
        tests++;
        if (OUT !== 16'h7856 || CARRY !== 1'b1) begin
            fails++; $display("FAIL load_hi_c got %h/%b want 7856/1", OUT, CARRY);
        end
    endtask

    task automatic test_reset_midseq;
        cyc(UREG_LOAD_LO, 16'h00CD, 1'b0);
        RESET = 1'b0;
        cyc(UREG_LOAD_HI, 16'h00AB, 1'b0);
        RESET = 1'b1;
        tests++;
        if (OUT !== 16'h0000 || CARRY !== 1'b0 || ZERO !== 1'b1) begin
            fails++; $display("FAIL reset_mid got %h/%b/%b want 0000/0/1", OUT, CARRY, ZERO);
        end
    endtask

    task automatic test_step4;
        RESET = 1'b0;
        mode4 = UREG_HOLD;
        cyc(UREG_HOLD, 16'h0000, 1'b0);
        RESET = 1'b1;
        mode4 = UREG_DEC;
        cyc(UREG_HOLD, 16'h0000, 1'b0);
        tests++;
        if (out4 !== 16'hFFFE || carry4 !== 1'b1) begin
            fails++; $display("FAIL step4_dec got %h/%b want fffe/1", out4, carry4);
        end
        mode4 = UREG_INC;
        cyc(UREG_HOLD, 16'h0000, 1'b0);
        tests++;
        if (out4 !== 16'h0002 || carry4 !== 1'b1) begin
            fails++; $display("FAIL step4_inc got %h/%b want 0002/1", out4, carry4);
        end
        mode4 = UREG_INC;
        cyc(UREG_HOLD, 16'h0000, 1'b0);
        tests++;
        if (out4 !== 16'h0006 || carry4 !== 1'b0) begin
            fails++; $display("FAIL step4_inc2 got %h/%b want 0006/0", out4, carry4);
        end
        mode4 = UREG_HOLD;
    endtask

    task automatic test_shadow;
        logic [15:0] exp_out;
`ifdef UREG_SHADOW_EN
        exp_out = 16'h00AA;
`else
        exp_out = 16'h5555;
`endif
        cyc(UREG_LOAD, 16'h00AA, 1'b0);
        SAVE = 1'b1;
        cyc(UREG_INC, 16'h0000, 1'b0);
        SAVE = 1'b0;
        tests++;
        if (OUT !== 16'h00AB) begin fails++; $display("FAIL save_inc got %h want 00ab", OUT); end
        cyc(UREG_LOAD, 16'h5555, 1'b0);
        RESTORE = 1'b1;
        cyc(UREG_HOLD, 16'h0000, 1'b0);
        RESTORE = 1'b0;
        tests++;
        if (OUT !== exp_out || CARRY !== 1'b0) begin
            fails++; $display("FAIL restore got %h/%b want %h/0", OUT, CARRY, exp_out);
        end
    endtask

    initial begin
        test_reset();
        test_inc_dec_wrap();
        test_shift();
        test_byte_lanes();
        test_reset_midseq();
        test_step4();
        test_shadow();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
